simple_if_to_axil: RTL and testbench
====================================

# simple_if_to_axil

AXI-Lite initiator that turns the single-beat simple memory interface (we/waddr/wdata/wstrb, re/raddr, two-bit responses) into AXI-Lite transactions driven onto a `dual_helix_pkg` AXI-Lite bus. It is the requester-side counterpart of the AXI-Lite-to-simple-interface converter used in front of register blocks such as the SoC control registers. It lets a simple-interface master, such as a debug/boot loader or a DMA engine, program any AXI-Lite target. Write and read paths are independent, each with at most one outstanding transaction.

## Interface
- `req_t`, `dual_helix_pkg::dhs_axil_req_t`: AXI-Lite request struct (AW, W, AR channels; B/R ready).
- `resp_t`, `dual_helix_pkg::dhs_axil_resp_t`: AXI-Lite response struct (AW/W/AR ready; B, R channels).
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 32: data width. Strobe width is DATA_WIDTH/8.

Ports:
- `clk_i` in 1: clock.
- `arst_ni` in 1: reset, asynchronous, active-low.
- `mem_we_i` in 1: write request.
- `mem_waddr_i` in ADDR_WIDTH: write address.
- `mem_wdata_i` in DATA_WIDTH: write data.
- `mem_wstrb_i` in DATA_WIDTH/8: byte strobes.
- `mem_wready_o` out 1: write path idle, request accepted when `mem_we_i` is also high.
- `mem_wdone_o` out 1: one-cycle write completion pulse.
- `mem_wresp_o` out 2: BRESP of the completed write.
- `mem_re_i` in 1: read request.
- `mem_raddr_i` in ADDR_WIDTH: read address.
- `mem_rready_o` out 1: read path idle.
- `mem_rdone_o` out 1: one-cycle read completion pulse.
- `mem_rdata_o` out DATA_WIDTH: RDATA of the last completed read.
- `mem_rresp_o` out 2: RRESP of the last completed read.
- `axil_req_o` out req_t: AXI-Lite request channels.
- `axil_resp_i` in resp_t: AXI-Lite response channels.

## Operation
- Write FSM states: W_IDLE, W_REQ, W_RESP.
  - W_IDLE: `mem_wready_o`=1. On `mem_we_i`, latch addr/data/strb, clear aw_done and w_done, go to W_REQ.
  - W_REQ: AWVALID = !aw_done; WVALID = !w_done. AW and W are driven in the same cycle and each drops independently on its own handshake. When both handshakes are complete (including both in the same cycle), go to W_RESP.
  - W_RESP: BREADY=1. On BVALID, register BRESP into `mem_wresp_o`, pulse `mem_wdone_o` next cycle, go to W_IDLE.
- Read FSM states: R_IDLE, R_ADDR, R_DATA.
  - R_IDLE: `mem_rready_o`=1. On `mem_re_i`, latch the address and go to R_ADDR.
  - R_ADDR: ARVALID=1. On ARREADY, go to R_DATA.
  - R_DATA: RREADY=1. On RVALID, register RDATA/RRESP, pulse `mem_rdone_o`, go to R_IDLE.
- AWPROT/ARPROT = 3'b000. Address, data and strobe are forwarded unmodified; no alignment check.
- Latched request fields and VALID stay stable until their handshake, as the AXI rules require. Changes on `mem_*` inputs after acceptance are ignored.
- Requests issued while the matching ready is low are ignored. The requester must hold `we`/`re` until ready.
- Read and write paths run concurrently. No ordering is enforced between them.
- `mem_rdata_o`/`mem_rresp_o` hold their value until the next read completes. `mem_wresp_o` holds until the next write completes.
- SLVERR/DECERR are reported verbatim in the resp outputs; no retry.

## Timing
- Reset values: all VALIDs 0, BREADY/RREADY 0, `mem_wready_o`/`mem_rready_o` 1, done pulses 0, `mem_wresp_o`/`mem_rresp_o` 2'b00, `mem_rdata_o` 0. FSMs reset to IDLE.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately and all VALIDs drop. Bus targets are reset together with this block.
- The acceptance edge is cycle 0.
  - AW/W/AR VALID are high from cycle 1 (registered).
  - Zero-wait target: AW+W handshake in cycle 1, B handshake in cycle 2, `mem_wdone_o` high in cycle 3.
  - Read: AR handshake in cycle 1, R handshake in cycle 2, `mem_rdone_o` high in cycle 3.
- The done cycle is also an IDLE cycle: ready=1, so a back-to-back request can be accepted in that cycle. Minimum issue interval is 3 cycles per path.
- BVALID/RVALID arriving before BREADY/RREADY are held by the target and are taken on entry to the RESP/DATA state.

## Test plan
- Zero-wait write: addr 0x0000_0010, data 0xDEAD_BEEF, strb 4'hF, target BRESP=OKAY.
  - AW and W seen together in cycle 1 with exact fields.
  - `mem_wdone_o` in cycle 3 with `mem_wresp_o`=2'b00.
- Skewed write handshakes: AWREADY 3 cycles late, WREADY 1 cycle late.
  - WVALID drops after its handshake while AWVALID stays high.
  - BREADY rises only after both handshakes complete.
  - A single done pulse.
- Read with 5-cycle RVALID delay, RDATA 0x1234_5678, RRESP=SLVERR.
  - `mem_rdata_o`=0x1234_5678 and `mem_rresp_o`=2'b10 on the done pulse.
  - Values held afterwards.
- Concurrent write and read issued in the same cycle: both complete independently with correct data and no cross-corruption.
- Back-to-back writes with `mem_we_i` held high: the second request is accepted in the done cycle of the first. Three writes finish in 9 cycles with zero-wait target.
- Reset mid-write (in W_REQ) followed by release:
  - All VALIDs 0 and readies 1 during reset.
  - A new write completes normally after release.

Source files
------------

// File: rtl/simple_if_to_axil.sv
// rtl/simple_if_to_axil.sv - simple memory interface to AXI-Lite initiator
//
// Converts single-beat simple-interface writes (we/waddr/wdata/wstrb) and
// reads (re/raddr) into AXI-Lite transactions. Write and read paths are
// independent FSMs, each with at most one outstanding transaction.
//
// Ports:
//   clk_i, arst_ni                 clock, asynchronous active-low reset
//   mem_we_i/waddr/wdata/wstrb     write request (accepted when mem_wready_o=1)
//   mem_wready_o                   write path idle
//   mem_wdone_o, mem_wresp_o       write completion pulse and its BRESP
//   mem_re_i/raddr                 read request (accepted when mem_rready_o=1)
//   mem_rready_o                   read path idle
//   mem_rdone_o, mem_rdata_o,
//   mem_rresp_o                    read completion pulse, RDATA and RRESP
//   axil_req_o / axil_resp_i       AXI-Lite request / response channels

package dual_helix_pkg;

    typedef struct packed {
        logic [31:0] aw_addr;
        logic [2:0]  aw_prot;
        logic        aw_valid;
        logic [31:0] w_data;
        logic [3:0]  w_strb;
        logic        w_valid;
        logic        b_ready;
        logic [31:0] ar_addr;
        logic [2:0]  ar_prot;
        logic        ar_valid;
        logic        r_ready;
    } dhs_axil_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        w_ready;
        logic [1:0]  b_resp;
        logic        b_valid;
        logic        ar_ready;
        logic [31:0] r_data;
        logic [1:0]  r_resp;
        logic        r_valid;
    } dhs_axil_resp_t;

endpackage

module simple_if_to_axil #(
    parameter type         req_t      = dual_helix_pkg::dhs_axil_req_t,
    parameter type         resp_t     = dual_helix_pkg::dhs_axil_resp_t,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    arst_ni,
    input  logic                    mem_we_i,
    input  logic [ADDR_WIDTH-1:0]   mem_waddr_i,
    input  logic [DATA_WIDTH-1:0]   mem_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] mem_wstrb_i,
    output logic                    mem_wready_o,
    output logic                    mem_wdone_o,
    output logic [1:0]              mem_wresp_o,
    input  logic                    mem_re_i,
    input  logic [ADDR_WIDTH-1:0]   mem_raddr_i,
    output logic                    mem_rready_o,
    output logic                    mem_rdone_o,
    output logic [DATA_WIDTH-1:0]   mem_rdata_o,
    output logic [1:0]              mem_rresp_o,
    output req_t                    axil_req_o,
    input  resp_t                   axil_resp_i
);

    typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;

    logic [ADDR_WIDTH-1:0]   waddr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] wstrb_q;
    logic                    aw_done_q;
    logic                    w_done_q;
    logic                    wdone_q;
    logic [1:0]              wresp_q;

    logic [ADDR_WIDTH-1:0]   raddr_q;
    logic                    rdone_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]              rresp_q;

    logic aw_valid, w_valid, b_ready, ar_valid, r_ready;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic w_accept, r_accept;

    // AW and W are tracked separately so each VALID drops on its own handshake.
    assign aw_valid = (w_state_q == W_REQ) && !aw_done_q;
    assign w_valid  = (w_state_q == W_REQ) && !w_done_q;
    assign b_ready  = (w_state_q == W_RESP);
    assign ar_valid = (r_state_q == R_ADDR);
    assign r_ready  = (r_state_q == R_DATA);

    assign aw_hs = aw_valid && axil_resp_i.aw_ready;
    assign w_hs  = w_valid  && axil_resp_i.w_ready;
    assign b_hs  = b_ready  && axil_resp_i.b_valid;
    assign ar_hs = ar_valid && axil_resp_i.ar_ready;
    assign r_hs  = r_ready  && axil_resp_i.r_valid;

    assign w_accept = mem_wready_o && mem_we_i;
    assign r_accept = mem_rready_o && mem_re_i;

    always_comb begin : w_fsm_comb
        w_state_d    = w_state_q;
        mem_wready_o = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                mem_wready_o = 1'b1;
                if (mem_we_i) begin
                    w_state_d = W_REQ;
                end
            end
            W_REQ: begin
                // Leave once both channels are through, whether they
                // completed in earlier cycles or in this one.
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (axil_resp_i.b_valid) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin : r_fsm_comb
        r_state_d    = r_state_q;
        mem_rready_o = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                mem_rready_o = 1'b1;
                if (mem_re_i) begin
                    r_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                if (axil_resp_i.ar_ready) begin
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (axil_resp_i.r_valid) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin : w_regs
        if (!arst_ni) begin
            w_state_q <= W_IDLE;
            waddr_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            wdone_q   <= 1'b0;
            wresp_q   <= 2'b00;
        end else begin
            w_state_q <= w_state_d;
            wdone_q   <= 1'b0;
            if (w_accept) begin
                waddr_q   <= mem_waddr_i;
                wdata_q   <= mem_wdata_i;
                wstrb_q   <= mem_wstrb_i;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end
            if (aw_hs) begin
                aw_done_q <= 1'b1;
            end
            if (w_hs) begin
                w_done_q <= 1'b1;
            end
            if (b_hs) begin
                wresp_q <= axil_resp_i.b_resp;
                wdone_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin : r_regs
        if (!arst_ni) begin
            r_state_q <= R_IDLE;
            raddr_q   <= '0;
            rdone_q   <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
        end else begin
            r_state_q <= r_state_d;
            rdone_q   <= 1'b0;
            if (r_accept) begin
                raddr_q <= mem_raddr_i;
            end
            if (r_hs) begin
                rdata_q <= axil_resp_i.r_data;
                rresp_q <= axil_resp_i.r_resp;
                rdone_q <= 1'b1;
            end
        end
    end

    assign mem_wdone_o = wdone_q;
    assign mem_wresp_o = wresp_q;
    assign mem_rdone_o = rdone_q;
    assign mem_rdata_o = rdata_q;
    assign mem_rresp_o = rresp_q;

    always_comb begin : req_pack
        axil_req_o          = '0;
        axil_req_o.aw_addr  = waddr_q;
        axil_req_o.aw_prot  = 3'b000;
        axil_req_o.aw_valid = aw_valid;
        axil_req_o.w_data   = wdata_q;
        axil_req_o.w_strb   = wstrb_q;
        axil_req_o.w_valid  = w_valid;
        axil_req_o.b_ready  = b_ready;
        axil_req_o.ar_addr  = raddr_q;
        axil_req_o.ar_prot  = 3'b000;
        axil_req_o.ar_valid = ar_valid;
        axil_req_o.r_ready  = r_ready;
    end

endmodule

// File: tb/tb_simple_if_to_axil.sv
// tb/tb_simple_if_to_axil.sv - scoreboard bench for simple_if_to_axil
module tb_simple_if_to_axil;
    import dual_helix_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_waddr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        mem_wready, mem_wdone;
    logic [1:0]  mem_wresp;
    logic        mem_re = 1'b0;
    logic [31:0] mem_raddr = '0;
    logic        mem_rready, mem_rdone;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_rresp;
    dhs_axil_req_t  axil_req;
    dhs_axil_resp_t axil_resp;

    simple_if_to_axil dut (
        .clk_i        (clk),
        .arst_ni      (rst_n),
        .mem_we_i     (mem_we),
        .mem_waddr_i  (mem_waddr),
        .mem_wdata_i  (mem_wdata),
        .mem_wstrb_i  (mem_wstrb),
        .mem_wready_o (mem_wready),
        .mem_wdone_o  (mem_wdone),
        .mem_wresp_o  (mem_wresp),
        .mem_re_i     (mem_re),
        .mem_raddr_i  (mem_raddr),
        .mem_rready_o (mem_rready),
        .mem_rdone_o  (mem_rdone),
        .mem_rdata_o  (mem_rdata),
        .mem_rresp_o  (mem_rresp),
        .axil_req_o   (axil_req),
        .axil_resp_i  (axil_resp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Target behaviour: configurable ready/valid delays, responses derived from address.
    int  aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    bit  rand_mode = 1'b0;
    bit  force_en = 1'b0;
    logic [1:0]  force_bresp = 2'b00, force_rresp = 2'b00;
    logic [31:0] force_rdata = '0;

    function automatic logic [1:0] ref_bresp(input logic [31:0] a);
        return force_en ? force_bresp : a[5:4];
    endfunction
    function automatic logic [1:0] ref_rresp(input logic [31:0] a);
        return force_en ? force_rresp : a[9:8];
    endfunction
    function automatic logic [31:0] ref_rdata(input logic [31:0] a);
        return force_en ? force_rdata : ({a[15:0], ~a[31:16]} ^ 32'hC3A5_5A3C);
    endfunction

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wreq_t;

    wreq_t       exp_aw_q[$];
    logic [1:0]  exp_wresp_q[$];
    logic [33:0] exp_r_q[$];

    int w_done_cnt = 0, r_done_cnt = 0;
    int last_wdone_cyc = 0;

    // Scoreboard monitor
    initial begin
        logic [1:0]  ew;
        logic [33:0] er;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mem_wdone) begin
                    w_done_cnt++;
                    last_wdone_cyc = cyc;
                    if (exp_wresp_q.size() == 0) fail_now("wdone_unexpected");
                    else begin
                        ew = exp_wresp_q.pop_front();
                        check("wresp", 64'(mem_wresp), 64'(ew));
                    end
                end
                if (mem_rdone) begin
                    r_done_cnt++;
                    if (exp_r_q.size() == 0) fail_now("rdone_unexpected");
                    else begin
                        er = exp_r_q.pop_front();
                        check("rdata", 64'(mem_rdata), 64'(er[31:0]));
                        check("rresp", 64'(mem_rresp), 64'(er[33:32]));
                    end
                end
            end
        end
    end

    // AXI-Lite target model
    initial begin
        bit aw_cap, w_cap, b_act, r_act;
        int aw_wait, w_wait, ar_wait, b_wait, r_wait;
        logic [31:0] cap_addr, cap_data, r_addr;
        logic [3:0]  cap_strb;
        bit p_aw_v, p_aw_r, p_w_v, p_w_r, p_ar_v, p_ar_r, p_b_v, p_b_r, p_r_v, p_r_r;
        logic [31:0] p_aw_addr, p_w_data, p_ar_addr;
        logic [3:0]  p_w_strb;
        logic [2:0]  p_aw_prot, p_ar_prot;
        wreq_t e;
        axil_resp = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                axil_resp = '0;
                aw_cap = 0; w_cap = 0; b_act = 0; r_act = 0;
                aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
                p_aw_v = 0; p_aw_r = 0; p_w_v = 0; p_w_r = 0; p_ar_v = 0;
                p_ar_r = 0; p_b_v = 0; p_b_r = 0; p_r_v = 0; p_r_r = 0;
            end else begin
                if (p_b_v && p_b_r) begin
                    b_act = 0; axil_resp.b_valid = 0; b_wait = 0;
                    if (rand_mode) b_dly = $urandom_range(0, 3);
                end
                if (p_r_v && p_r_r) begin
                    r_act = 0; axil_resp.r_valid = 0; r_wait = 0;
                    if (rand_mode) r_dly = $urandom_range(0, 4);
                end
                if (p_aw_v && p_aw_r) begin
                    aw_cap = 1; cap_addr = p_aw_addr; aw_wait = 0;
                    check("aw_prot", 64'(p_aw_prot), 64'd0);
                    if (rand_mode) aw_dly = $urandom_range(0, 3);
                end else if (p_aw_v) begin
                    check("aw_valid_held", 64'(axil_req.aw_valid), 64'd1);
                    check("aw_addr_stable", 64'(axil_req.aw_addr), 64'(p_aw_addr));
                end
                if (p_w_v && p_w_r) begin
                    w_cap = 1; cap_data = p_w_data; cap_strb = p_w_strb; w_wait = 0;
                    if (rand_mode) w_dly = $urandom_range(0, 3);
                end else if (p_w_v) begin
                    check("w_valid_held", 64'(axil_req.w_valid), 64'd1);
                    check("w_data_stable", 64'(axil_req.w_data), 64'(p_w_data));
                end
                if (p_ar_v && p_ar_r) begin
                    r_act = 1; r_addr = p_ar_addr; r_wait = 0; ar_wait = 0;
                    check("ar_prot", 64'(p_ar_prot), 64'd0);
                    if (rand_mode) ar_dly = $urandom_range(0, 3);
                end else if (p_ar_v) begin
                    check("ar_valid_held", 64'(axil_req.ar_valid), 64'd1);
                    check("ar_addr_stable", 64'(axil_req.ar_addr), 64'(p_ar_addr));
                end
                if (aw_cap && w_cap && !b_act) begin
                    b_act = 1; b_wait = 0; aw_cap = 0; w_cap = 0;
                    axil_resp.b_resp = ref_bresp(cap_addr);
                    if (exp_aw_q.size() == 0) fail_now("aw_w_unexpected");
                    else begin
                        e = exp_aw_q.pop_front();
                        check("aw_addr", 64'(cap_addr), 64'(e.addr));
                        check("w_data", 64'(cap_data), 64'(e.data));
                        check("w_strb", 64'(cap_strb), 64'(e.strb));
                    end
                end
                if (b_act && !axil_resp.b_valid) begin
                    if (b_wait >= b_dly) axil_resp.b_valid = 1;
                    else b_wait++;
                end
                if (r_act && !axil_resp.r_valid) begin
                    if (r_wait >= r_dly) begin
                        axil_resp.r_valid = 1;
                        axil_resp.r_data = ref_rdata(r_addr);
                        axil_resp.r_resp = ref_rresp(r_addr);
                    end else r_wait++;
                end
                if (axil_req.aw_valid && !aw_cap) begin
                    axil_resp.aw_ready = (aw_wait >= aw_dly);
                    if (aw_wait < aw_dly) aw_wait++;
                end else axil_resp.aw_ready = 0;
                if (axil_req.w_valid && !w_cap) begin
                    axil_resp.w_ready = (w_wait >= w_dly);
                    if (w_wait < w_dly) w_wait++;
                end else axil_resp.w_ready = 0;
                if (axil_req.ar_valid && !r_act) begin
                    axil_resp.ar_ready = (ar_wait >= ar_dly);
                    if (ar_wait < ar_dly) ar_wait++;
                end else axil_resp.ar_ready = 0;
                p_aw_v = axil_req.aw_valid; p_aw_r = axil_resp.aw_ready;
                p_aw_addr = axil_req.aw_addr; p_aw_prot = axil_req.aw_prot;
                p_w_v = axil_req.w_valid; p_w_r = axil_resp.w_ready;
                p_w_data = axil_req.w_data; p_w_strb = axil_req.w_strb;
                p_ar_v = axil_req.ar_valid; p_ar_r = axil_resp.ar_ready;
                p_ar_addr = axil_req.ar_addr; p_ar_prot = axil_req.ar_prot;
                p_b_v = axil_resp.b_valid; p_b_r = axil_req.b_ready;
                p_r_v = axil_resp.r_valid; p_r_r = axil_req.r_ready;
            end
        end
    end

    task automatic present_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        mem_we = 1'b1; mem_waddr = a; mem_wdata = d; mem_wstrb = s;
        exp_aw_q.push_back({a, d, s});
        exp_wresp_q.push_back(ref_bresp(a));
    endtask

    task automatic present_read(input logic [31:0] a);
        mem_re = 1'b1; mem_raddr = a;
        exp_r_q.push_back({ref_rresp(a), ref_rdata(a)});
    endtask

    task automatic wait_wready();
        int n = 0;
        while (!mem_wready && n < 200) begin @(negedge clk); n++; end
        if (!mem_wready) fail_now("wready_timeout");
    endtask

    task automatic wait_rready();
        int n = 0;
        while (!mem_rready && n < 200) begin @(negedge clk); n++; end
        if (!mem_rready) fail_now("rready_timeout");
    endtask

    task automatic wait_wcnt(input int tgt);
        int n = 0;
        while (w_done_cnt < tgt && n < 200) begin @(negedge clk); n++; end
        if (w_done_cnt < tgt) fail_now("wdone_timeout");
    endtask

    task automatic wait_rcnt(input int tgt);
        int n = 0;
        while (r_done_cnt < tgt && n < 200) begin @(negedge clk); n++; end
        if (r_done_cnt < tgt) fail_now("rdone_timeout");
    endtask

    task automatic set_delays(input int aw, input int w, input int b, input int ar, input int r);
        aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, t0, n;
        repeat (3) @(negedge clk);
        check("rst_aw_valid", 64'(axil_req.aw_valid), 64'd0);
        check("rst_w_valid", 64'(axil_req.w_valid), 64'd0);
        check("rst_ar_valid", 64'(axil_req.ar_valid), 64'd0);
        check("rst_b_ready", 64'(axil_req.b_ready), 64'd0);
        check("rst_r_ready", 64'(axil_req.r_ready), 64'd0);
        check("rst_wready", 64'(mem_wready), 64'd1);
        check("rst_rready", 64'(mem_rready), 64'd1);
        check("rst_wdone", 64'(mem_wdone), 64'd0);
        check("rst_rdone", 64'(mem_rdone), 64'd0);
        check("rst_wresp", 64'(mem_wresp), 64'd0);
        check("rst_rresp", 64'(mem_rresp), 64'd0);
        check("rst_rdata", 64'(mem_rdata), 64'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Zero-wait write
        set_delays(0, 0, 0, 0, 0);
        force_en = 1'b1; force_bresp = 2'b00;
        wait_wready();
        present_write(32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        @(negedge clk); mem_we = 1'b0;
        check("zw_c1_aw_valid", 64'(axil_req.aw_valid), 64'd1);
        check("zw_c1_w_valid", 64'(axil_req.w_valid), 64'd1);
        check("zw_c1_aw_addr", 64'(axil_req.aw_addr), 64'h10);
        check("zw_c1_w_data", 64'(axil_req.w_data), 64'hDEAD_BEEF);
        check("zw_c1_w_strb", 64'(axil_req.w_strb), 64'hF);
        @(negedge clk);
        check("zw_c2_b_ready", 64'(axil_req.b_ready), 64'd1);
        @(negedge clk);
        check("zw_c3_wdone", 64'(mem_wdone), 64'd1);
        check("zw_c3_wresp", 64'(mem_wresp), 64'd0);
        check("zw_c3_wready", 64'(mem_wready), 64'd1);

        // Skewed AW/W handshakes
        set_delays(3, 1, 0, 0, 0);
        force_bresp = 2'b01;
        wait_wready();
        base = w_done_cnt;
        present_write(32'h0000_0104, 32'hA5A5_0F0F, 4'h6);
        @(negedge clk); mem_we = 1'b0;
        check("sk_c1_w_valid", 64'(axil_req.w_valid), 64'd1);
        @(negedge clk);
        check("sk_c2_w_valid", 64'(axil_req.w_valid), 64'd1);
        @(negedge clk);
        check("sk_c3_w_valid", 64'(axil_req.w_valid), 64'd0);
        check("sk_c3_aw_valid", 64'(axil_req.aw_valid), 64'd1);
        check("sk_c3_b_ready", 64'(axil_req.b_ready), 64'd0);
        @(negedge clk);
        check("sk_c4_aw_valid", 64'(axil_req.aw_valid), 64'd1);
        check("sk_c4_b_ready", 64'(axil_req.b_ready), 64'd0);
        @(negedge clk);
        check("sk_c5_aw_valid", 64'(axil_req.aw_valid), 64'd0);
        check("sk_c5_b_ready", 64'(axil_req.b_ready), 64'd1);
        @(negedge clk);
        check("sk_c6_wdone", 64'(mem_wdone), 64'd1);
        repeat (4) @(negedge clk);
        check("sk_single_pulse", 64'(w_done_cnt - base), 64'd1);

        // Read, delayed RVALID, SLVERR
        set_delays(0, 0, 0, 0, 5);
        force_rdata = 32'h1234_5678; force_rresp = 2'b10;
        wait_rready();
        base = r_done_cnt;
        present_read(32'h0000_0200);
        @(negedge clk); mem_re = 1'b0;
        n = 0;
        while (!mem_rdone && n < 50) begin @(negedge clk); n++; end
        check("rd_done_seen", 64'(mem_rdone), 64'd1);
        check("rd_data", 64'(mem_rdata), 64'h1234_5678);
        check("rd_resp", 64'(mem_rresp), 64'd2);
        repeat (3) @(negedge clk);
        check("rd_data_held", 64'(mem_rdata), 64'h1234_5678);
        check("rd_resp_held", 64'(mem_rresp), 64'd2);
        check("rd_count", 64'(r_done_cnt - base), 64'd1);

        // Concurrent write and read in the same cycle
        force_en = 1'b0;
        set_delays($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3));
        wait_wready(); wait_rready();
        base = w_done_cnt; t0 = r_done_cnt;
        present_write($urandom, $urandom, 4'($urandom));
        present_read($urandom);
        @(negedge clk); mem_we = 1'b0; mem_re = 1'b0;
        wait_wcnt(base + 1);
        wait_rcnt(t0 + 1);

        // Back-to-back writes with we held high
        set_delays(0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        base = w_done_cnt;
        t0 = 0;
        for (int k = 0; k < 3; k++) begin
            wait_wready();
            if (k == 0) t0 = cyc;
            present_write($urandom, $urandom, 4'($urandom));
            @(negedge clk);
        end
        mem_we = 1'b0;
        wait_wcnt(base + 3);
        check("b2b_9_cycles", 64'(last_wdone_cyc - t0), 64'd9);

        // Reset in W_REQ
        set_delays(10, 10, 0, 0, 0);
        wait_wready();
        present_write(32'h0000_0300, 32'h0BAD_F00D, 4'h3);
        @(negedge clk); mem_we = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        exp_aw_q.delete(); exp_wresp_q.delete();
        #1;
        check("mr_aw_valid", 64'(axil_req.aw_valid), 64'd0);
        check("mr_w_valid", 64'(axil_req.w_valid), 64'd0);
        check("mr_ar_valid", 64'(axil_req.ar_valid), 64'd0);
        check("mr_wready", 64'(mem_wready), 64'd1);
        check("mr_rready", 64'(mem_rready), 64'd1);
        repeat (2) @(negedge clk);
        set_delays(0, 0, 0, 0, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        base = w_done_cnt;
        wait_wready();
        present_write(32'h0000_0320, 32'hCAFE_0001, 4'hF);
        @(negedge clk); mem_we = 1'b0;
        wait_wcnt(base + 1);

        // Randomized concurrent traffic
        rand_mode = 1'b1;
        set_delays($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 4));
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    wait_wready();
                    present_write($urandom, $urandom, 4'($urandom));
                    @(negedge clk); mem_we = 1'b0;
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
            begin
                for (int i = 0; i < 30; i++) begin
                    wait_rready();
                    present_read($urandom);
                    @(negedge clk); mem_re = 1'b0;
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
        join
        n = 0;
        while ((exp_wresp_q.size() != 0 || exp_r_q.size() != 0) && n < 300) begin
            @(negedge clk); n++;
        end
        check("drain_wq", 64'(exp_wresp_q.size()), 64'd0);
        check("drain_rq", 64'(exp_r_q.size()), 64'd0);
        check("drain_awq", 64'(exp_aw_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
